// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: FSM states, LSB access
// lengths, ICache block geometry and the IO region marker.
package mem_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int BLOCK_WIDTH = 1;
    localparam int BLOCK_BYTES = 4 << BLOCK_WIDTH;
    localparam int BLOCK_BITS  = 8 * BLOCK_BYTES;

    // Low address bits cleared to find the start of an ICache block
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(BLOCK_BYTES - 1);

    // addr[17:16] value that selects the IO region
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        LOAD,
        STORE,
        COOL
    } state_t;

    typedef enum logic [1:0] {
        LEN_B = 2'b00,
        LEN_H = 2'b01,
        LEN_W = 2'b10
    } len_t;

    // Byte count of an LSB access; the illegal encoding 11 behaves as a word
    function automatic logic [3:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_to_bytes = 4'd1;
            LEN_H:   len_to_bytes = 4'd2;
            default: len_to_bytes = 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: turns ICache block refills and LSB loads/stores into a
// stream of single-byte RAM accesses, reassembles read data and returns it
// with a one-cycle done pulse. LSB requests win arbitration over refills, and
// stores into the IO region wait while the IO buffer is full.
module mem_ctrl
    import mem_pkg::*;
(
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,

    input  logic                  ICMC_en,
    input  logic [ADDR_WIDTH-1:0] ICMC_addr,
    output logic                  MCIC_en,
    output logic [BLOCK_BITS-1:0] MCIC_block,

    input  logic                  LSBMC_en,
    input  logic                  LSBMC_wr,
    input  logic [1:0]            LSBMC_len,
    input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
    input  logic [31:0]           LSBMC_data,
    output logic                  MCLSB_r_en,
    output logic                  MCLSB_w_en,
    output logic [31:0]           MCLSB_data,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    state_t                  state;
    logic [3:0]              cnt;
    logic [3:0]              nbytes;
    logic [ADDR_WIDTH-1:0]   base;
    logic [31:0]             st_data;
    logic [BLOCK_BITS-1:0]   asm_q;
    logic                    wr_q;
    logic                    rdy_q;
    logic [7:0]              din_hold;

    logic [7:0]              byte_in;
    logic [2:0]              lane;
    logic [1:0]              next_sel;
    logic [BLOCK_BITS-1:0]   assembled;
    logic                    io_stall;

    // The RAM keeps running while Sys_rdy is low, so after a freeze mem_din
    // already shows the byte of the frozen address. The byte that was due is
    // parked in din_hold at the first frozen edge and used on resume.
    assign byte_in  = rdy_q ? mem_din : din_hold;
    assign lane     = 3'(cnt - 4'd1);
    assign next_sel = 2'(cnt[1:0] + 2'd1);

    // A store byte aimed at the IO region is held back while the IO buffer is full
    assign io_stall = (state == STORE) && (mem_a[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign mem_wr   = wr_q & ~io_stall;

    // Merge the byte arriving this cycle into its lane of the assembly register
    always_comb begin
        assembled = asm_q;
        assembled[{lane, 3'b000} +: 8] = byte_in;
    end

    // Request arbitration, byte sequencing, data assembly and done pulses
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            nbytes     <= '0;
            base       <= '0;
            st_data    <= '0;
            asm_q      <= '0;
            wr_q       <= 1'b0;
            rdy_q      <= 1'b1;
            din_hold   <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            MCIC_en    <= 1'b0;
            MCIC_block <= '0;
            MCLSB_r_en <= 1'b0;
            MCLSB_w_en <= 1'b0;
            MCLSB_data <= '0;
        end else begin
            rdy_q <= Sys_rdy;
            if (rdy_q) begin
                din_hold <= mem_din;
            end

            if (Sys_rdy) begin
                MCIC_en    <= 1'b0;
                MCLSB_r_en <= 1'b0;
                MCLSB_w_en <= 1'b0;

                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        asm_q <= '0;
                        if (LSBMC_en) begin
                            base    <= LSBMC_addr;
                            st_data <= LSBMC_data;
                            nbytes  <= len_to_bytes(LSBMC_len);
                            mem_a   <= LSBMC_addr;
                            if (LSBMC_wr) begin
                                mem_dout <= LSBMC_data[7:0];
                                wr_q     <= 1'b1;
                                state    <= STORE;
                            end else begin
                                state <= LOAD;
                            end
                        end else if (ICMC_en) begin
                            base   <= ICMC_addr & ~BLOCK_MASK;
                            nbytes <= 4'(BLOCK_BYTES);
                            mem_a  <= ICMC_addr & ~BLOCK_MASK;
                            state  <= IFETCH;
                        end
                    end

                    IFETCH, LOAD: begin
                        if (cnt != 4'd0) begin
                            asm_q <= assembled;
                        end
                        if ((cnt + 4'd1) < nbytes) begin
                            mem_a <= base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
                        end
                        if (cnt == nbytes) begin
                            if (state == IFETCH) begin
                                MCIC_en    <= 1'b1;
                                MCIC_block <= assembled;
                            end else begin
                                MCLSB_r_en <= 1'b1;
                                MCLSB_data <= assembled[31:0];
                            end
                            state <= COOL;
                        end
                        cnt <= cnt + 4'd1;
                    end

                    STORE: begin
                        if (!io_stall) begin
                            if (cnt == (nbytes - 4'd1)) begin
                                wr_q       <= 1'b0;
                                MCLSB_w_en <= 1'b1;
                                state      <= COOL;
                            end else begin
                                cnt      <= cnt + 4'd1;
                                mem_a    <= base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
                                mem_dout <= st_data[{next_sel, 3'b000} +: 8];
                            end
                        end
                    end

                    COOL: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end

                    default: begin
                        wr_q  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-wide RAM model, requester tasks
// that queue the expected responses, and a negedge monitor that pops and
// compares whenever a done pulse or a RAM write appears.
module tb_mem_ctrl;

    logic        Sys_clk;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic        ICMC_en;
    logic [31:0] ICMC_addr;
    logic        MCIC_en;
    logic [63:0] MCIC_block;
    logic        LSBMC_en;
    logic        LSBMC_wr;
    logic [1:0]  LSBMC_len;
    logic [31:0] LSBMC_addr;
    logic [31:0] LSBMC_data;
    logic        MCLSB_r_en;
    logic        MCLSB_w_en;
    logic [31:0] MCLSB_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t ic_q[$];
    exp_t ld_q[$];
    int   st_q[$];
    wr_t  wr_q[$];

    logic [7:0] ram [bit [31:0]];

    int cyc      = 0;
    int total    = 0;
    int failures = 0;

    mem_ctrl dut (
        .Sys_clk        (Sys_clk),
        .Sys_rst        (Sys_rst),
        .Sys_rdy        (Sys_rdy),
        .ICMC_en        (ICMC_en),
        .ICMC_addr      (ICMC_addr),
        .MCIC_en        (MCIC_en),
        .MCIC_block     (MCIC_block),
        .LSBMC_en       (LSBMC_en),
        .LSBMC_wr       (LSBMC_wr),
        .LSBMC_len      (LSBMC_len),
        .LSBMC_addr     (LSBMC_addr),
        .LSBMC_data     (LSBMC_data),
        .MCLSB_r_en     (MCLSB_r_en),
        .MCLSB_w_en     (MCLSB_w_en),
        .MCLSB_data     (MCLSB_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    // Free-running clock and cycle counter
    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    always @(posedge Sys_clk) cyc <= cyc + 1;

    // RAM model: mem_din carries the byte addressed in the previous cycle
    always @(posedge Sys_clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        failures++;
        $display("[TB] FAIL %s: got an event or timeout, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    // Issue one request, queue its expected response, then hold the enable
    // until the done pulse is seen (plus 'lag' extra cycles)
    task automatic applyStimulus(input bit is_refill, input logic wr, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [63:0] exp_data, input int lat, input int lag);
        exp_t e;
        wr_t  w;
        int   n;
        bit   seen;
        n      = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        e.data = exp_data;
        e.due  = cyc + 1 + lat;
        if (is_refill) begin
            ic_q.push_back(e);
            ICMC_addr = addr;
            ICMC_en   = 1'b1;
        end else begin
            if (wr) begin
                st_q.push_back(e.due);
                for (int k = 0; k < n; k++) begin
                    w.a = addr + 32'(k);
                    w.d = data[8*k +: 8];
                    wr_q.push_back(w);
                end
            end else begin
                ld_q.push_back(e);
            end
            LSBMC_wr   = wr;
            LSBMC_len  = len;
            LSBMC_addr = addr;
            LSBMC_data = data;
            LSBMC_en   = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (is_refill) seen = MCIC_en;
            else           seen = wr ? MCLSB_w_en : MCLSB_r_en;
        end
        repeat (lag) tick();
        if (is_refill) ICMC_en = 1'b0;
        else           LSBMC_en = 1'b0;
        if (!seen) reportFail(is_refill ? "refill_timeout" : "lsb_timeout");
    endtask

    // Monitor: pop and compare whenever the DUT presents a done pulse or a write
    always @(negedge Sys_clk) begin : monitor
        exp_t e;
        wr_t  w;
        int   due;
        if (MCIC_en || MCLSB_r_en || MCLSB_w_en)
            checkOutput("done_onehot", 64'($countones({MCIC_en, MCLSB_r_en, MCLSB_w_en})), 64'd1);
        if (MCIC_en) begin
            if (ic_q.size() == 0) reportFail("refill_unexpected");
            else begin
                e = ic_q.pop_front();
                checkOutput("refill_data", MCIC_block, e.data);
                checkOutput("refill_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (MCLSB_r_en) begin
            if (ld_q.size() == 0) reportFail("load_unexpected");
            else begin
                e = ld_q.pop_front();
                checkOutput("load_data", 64'(MCLSB_data), e.data);
                checkOutput("load_latency", 64'(cyc), 64'(e.due));
            end
        end
        if (MCLSB_w_en) begin
            if (st_q.size() == 0) reportFail("store_unexpected");
            else begin
                due = st_q.pop_front();
                checkOutput("store_latency", 64'(cyc), 64'(due));
            end
        end
        if (mem_wr) begin
            if (wr_q.size() == 0) reportFail("write_unexpected");
            else begin
                w = wr_q.pop_front();
                checkOutput("write_addr", 64'(mem_a), 64'(w.a));
                checkOutput("write_data", 64'(mem_dout), 64'(w.d));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        Sys_rst        = 1'b1;
        Sys_rdy        = 1'b1;
        ICMC_en        = 1'b0;
        ICMC_addr      = '0;
        LSBMC_en       = 1'b0;
        LSBMC_wr       = 1'b0;
        LSBMC_len      = 2'b00;
        LSBMC_addr     = '0;
        LSBMC_data     = '0;
        io_buffer_full = 1'b0;

        for (int k = 0; k < 8; k++) ram[32'h100 + k] = 8'(k);
        ram[32'h20] = 8'hEF; ram[32'h21] = 8'hBE; ram[32'h22] = 8'hAD; ram[32'h23] = 8'hDE;
        ram[32'h80] = 8'h80; ram[32'h81] = 8'hFF;
        ram[32'h33] = 8'h5A;
        ram[32'h40] = 8'h11; ram[32'h41] = 8'h22; ram[32'h42] = 8'h33; ram[32'h43] = 8'h44;
        for (int k = 0; k < 8; k++) ram[32'h208 + k] = 8'hA0 + 8'(k);
        for (int k = 0; k < 8; k++) ram[32'h300 + k] = 8'hC0 + 8'(k);

        // Reset values
        repeat (2) tick();
        checkOutput("reset_MCIC_en", 64'(MCIC_en), 64'd0);
        checkOutput("reset_r_en", 64'(MCLSB_r_en), 64'd0);
        checkOutput("reset_w_en", 64'(MCLSB_w_en), 64'd0);
        checkOutput("reset_mem_wr", 64'(mem_wr), 64'd0);
        checkOutput("reset_mem_a", 64'(mem_a), 64'd0);
        checkOutput("reset_mem_dout", 64'(mem_dout), 64'd0);
        checkOutput("reset_MCIC_block", MCIC_block, 64'd0);
        checkOutput("reset_MCLSB_data", 64'(MCLSB_data), 64'd0);
        Sys_rst = 1'b0;
        tick();

        // Block refill from a mid-block address; enable lingers one cycle past
        // the pulse and must not start a second refill
        fork
            applyStimulus(1'b1, 1'b0, 2'b00, 32'h104, 32'h0, 64'h0706050403020100, 9, 1);
            begin
                tick();
                for (int k = 0; k < 8; k++) begin
                    checkOutput("refill_addr", 64'(mem_a), 64'(32'h100 + k));
                    tick();
                end
            end
        join
        repeat (2) tick();

        // Word load and zero-extended byte load
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 64'hDEADBEEF, 5, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h80, 32'h0, 64'h00000080, 2, 0);
        tick();

        // Unaligned half store; the neighbouring byte must stay intact
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h31, 32'h1234ABCD, 64'h0, 2, 0);
        tick();
        checkOutput("ram_0x32", 64'(ram[32'h32]), 64'hAB);
        checkOutput("ram_0x33_untouched", 64'(ram[32'h33]), 64'h5A);

        // IO store throttled for three cycles
        io_buffer_full = 1'b1;
        fork
            applyStimulus(1'b0, 1'b1, 2'b00, 32'h30000, 32'h00000077, 64'h0, 4, 0);
            begin
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checkOutput("io_throttle_wr", 64'(mem_wr), 64'd0);
                end
                tick();
                io_buffer_full = 1'b0;
                #1;
                checkOutput("io_release_wr", 64'(mem_wr), 64'd1);
            end
        join
        tick();

        // Simultaneous requests: load first, cool-down, then refill
        fork
            applyStimulus(1'b0, 1'b0, 2'b10, 32'h40, 32'h0, 64'h44332211, 5, 0);
            applyStimulus(1'b1, 1'b0, 2'b00, 32'h20C, 32'h0, 64'hA7A6A5A4A3A2A1A0, 16, 0);
        join
        tick();

        // Reset after four refill bytes: everything back to reset values, no pulse
        ICMC_addr = 32'h300;
        ICMC_en   = 1'b1;
        repeat (6) tick();
        Sys_rst = 1'b1;
        ICMC_en = 1'b0;
        tick();
        checkOutput("abort_MCIC_en", 64'(MCIC_en), 64'd0);
        checkOutput("abort_mem_a", 64'(mem_a), 64'd0);
        checkOutput("abort_mem_dout", 64'(mem_dout), 64'd0);
        checkOutput("abort_MCIC_block", MCIC_block, 64'd0);
        checkOutput("abort_MCLSB_data", 64'(MCLSB_data), 64'd0);
        Sys_rst = 1'b0;
        repeat (15) tick();

        // Two frozen cycles mid-load stretch the latency by exactly two
        fork
            applyStimulus(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 64'hDEADBEEF, 7, 0);
            begin
                repeat (3) tick();
                Sys_rdy = 1'b0;
                repeat (2) tick();
                Sys_rdy = 1'b1;
            end
        join
        repeat (3) tick();

        checkOutput("refill_queue_drained", 64'(ic_q.size()), 64'd0);
        checkOutput("load_queue_drained", 64'(ld_q.size()), 64'd0);
        checkOutput("store_queue_drained", 64'(st_q.size()), 64'd0);
        checkOutput("write_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", total, failures);
        $finish;
    end

endmodule
